// File: rtl/invert_pkg.sv
// -----------------------------------------------------------------------------
// invert_pkg
// Shared definitions for the clocked inversion pipeline.
//   DEFAULT_WIDTH  : default data width of a pipeline word
//   DEFAULT_DEPTH  : default number of register stages (zero-stall latency)
//   DEFAULT_CNT_W  : default width of the output edge counter
//   stage_t        : one stage record (valid flag + data) at the default width,
//                    handy for monitors and benches that observe a slice
// -----------------------------------------------------------------------------
package invert_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_t;

endpackage : invert_pkg

// File: rtl/invert_stage.sv
// -----------------------------------------------------------------------------
// invert_stage
// One elastic register slice of the inversion pipeline. Holds at most one word
// and passes it downstream under a valid/ready handshake.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : upstream offers a word
//   in_ready   : this slice takes a word this cycle (combinational)
//   in_data    : upstream word
//   out_valid  : this slice holds a word
//   out_ready  : downstream takes the held word this cycle
//   out_data   : held word (keeps its last value while empty)
// -----------------------------------------------------------------------------
module invert_stage
  import invert_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Empty, or the held word leaves this very cycle. This is what lets bubbles
  // collapse while the far end is stalled.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // its neighbour's pre-edge value; blocking here would let a word race through
  // several slices in a single clock.
  // NOTE: the data register is reset too, not just the valid flag, so the last
  // stage shows a known 0 after reset instead of X in mixed-signal co-sim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule : invert_stage

// File: rtl/invert_pipe.sv
// -----------------------------------------------------------------------------
// invert_pipe
// DEPTH-stage elastic pipeline that applies a programmable per-bit inversion at
// entry and reports changes between successive words leaving the pipeline.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   inv_en       : apply INV_MASK to the word accepted this cycle
//   in_valid     : input word present
//   in_ready     : stage 0 can accept this cycle
//   in_data      : input word
//   out_valid    : last stage holds a word
//   out_ready    : consumer accepts this cycle
//   out_data     : last-stage word (holds last value while out_valid=0)
//   out_changed  : registered pulse, accepted word differed from the previous one
//   edge_count   : number of out_changed pulses, wrapping modulo 2^CNT_W
// -----------------------------------------------------------------------------
module invert_pipe
  import invert_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] INV_MASK = '1,
  parameter int               CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_changed,
  output logic [CNT_W-1:0] edge_count
);

  // Inversion happens once, on entry; in-flight words never see inv_en again.
  logic [WIDTH-1:0] entry_data;
  assign entry_data = in_data ^ (inv_en ? INV_MASK : '0);

  // Each slice keeps its own link signals so the ready chain, which runs
  // combinationally from out_ready back to in_ready, is a plain wire path
  // rather than a self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_ready;
    logic             dn_ready;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = entry_data;
    end else begin : g_link
      assign up_valid = g_stage[k-1].q_valid;
      assign up_data  = g_stage[k-1].q_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].up_ready;
    end

    invert_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (up_data),
      .out_valid (q_valid),
      .out_ready (dn_ready),
      .out_data  (q_data)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[DEPTH-1].q_valid;
  assign out_data  = g_stage[DEPTH-1].q_data;

  // Edge detector: compares each accepted output word with the previously
  // accepted one; last_out starts at 0 so the first word is compared to 0.
  logic             out_xfer;
  logic             out_diff;
  logic [WIDTH-1:0] last_out;

  assign out_xfer = out_valid && out_ready;
  assign out_diff = out_xfer && (out_data != last_out);

  // The counter moves on the same edge that raises out_changed, so edge_count
  // already includes the pulse that is currently visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_out    <= '0;
      out_changed <= 1'b0;
      edge_count  <= '0;
    end else begin
      out_changed <= out_diff;
      if (out_xfer) begin
        last_out <= out_data;
      end
      if (out_diff) begin
        edge_count <= edge_count + 1'b1;
      end
    end
  end

endmodule : invert_pipe

// File: tb/tb_invert_pipe.sv
// -----------------------------------------------------------------------------
// tb_invert_pipe
// Drives two instances (16-bit and 2-bit edge counters) with identical stimulus
// and compares them each cycle against a queue-based reference model: a word
// accepted in cycle t may leave no earlier than t+DEPTH and no earlier than one
// cycle after the word ahead of it left; the pipeline accepts whenever it holds
// fewer than DEPTH words or the consumer is taking a word.
// -----------------------------------------------------------------------------
module tb_invert_pipe;
  import invert_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         inv_en;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready, out_valid, out_changed;
  logic [W-1:0] out_data;
  logic [15:0]  edge_count;

  logic         w_in_ready, w_out_valid, w_out_changed;
  logic [W-1:0] w_out_data;
  logic [1:0]   w_edge_count;

  invert_pipe #(
    .WIDTH(W), .DEPTH(D), .INV_MASK(8'hFF), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .inv_en(inv_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_changed(out_changed),
    .edge_count(edge_count)
  );

  invert_pipe #(
    .WIDTH(W), .DEPTH(D), .INV_MASK(8'hFF), .CNT_W(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .inv_en(inv_en), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_data(in_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .out_changed(w_out_changed),
    .edge_count(w_edge_count)
  );

  typedef struct {
    logic [W-1:0] data;
    int           t;
  } word_t;

  word_t        q[$];
  int           cyc;
  int           last_exit;
  logic [W-1:0] m_last;
  logic         m_changed;
  int           m_count;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    last_exit = -100;
    m_last    = '0;
    m_changed = 1'b0;
    m_count   = 0;
  endfunction

  // One clock cycle: apply inputs just after the falling edge, compare outputs
  // against the model, advance the model, then move to the next falling edge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ie,
                      input logic ordy);
    bit    exp_ov;
    bit    exp_ir;
    int    arr;
    word_t w;
    in_valid  = iv;
    in_data   = id;
    inv_en    = ie;
    out_ready = ordy;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) begin
      arr = q[0].t + D;
      if (last_exit + 1 > arr) arr = last_exit + 1;
      exp_ov = (cyc >= arr);
    end
    exp_ir = (q.size() < D) || ordy;

    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) check("out_data", out_data, q[0].data);
    check("out_changed", out_changed, m_changed);
    check("edge_count", edge_count, m_count & 32'hFFFF);
    check("wrap_edge_count", w_edge_count, m_count & 3);
    check("wrap_out_valid", w_out_valid, exp_ov);

    m_changed = 1'b0;
    if (exp_ov && ordy) begin
      m_changed = (q[0].data != m_last);
      m_last    = q[0].data;
      if (m_changed) m_count++;
      void'(q.pop_front());
      last_exit = cyc;
    end
    if (iv && exp_ir) begin
      w.data = id ^ (ie ? 8'hFF : 8'h00);
      w.t    = cyc;
      q.push_back(w);
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    inv_en    = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_out_changed", out_changed, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Inverted stream, free-flowing output
    step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h0F, 1'b1, 1'b1);
    step(1'b1, 8'h0F, 1'b1, 1'b1);
    step(1'b1, 8'hA5, 1'b1, 1'b1);
    repeat (6) step(1'b0, W'($urandom), 1'b1, 1'b1);
    check("stream_edge_count", edge_count, 3);

    // Non-inverted word, inv_en toggled while it is in flight
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    step(1'b0, W'($urandom), 1'b1, 1'b1);
    step(1'b0, W'($urandom), 1'b0, 1'b1);
    step(1'b0, W'($urandom), 1'b1, 1'b1);
    step(1'b0, W'($urandom), 1'b0, 1'b1);
    repeat (4) step(1'b0, W'($urandom), 1'b0, 1'b1);

    // Back-pressure: fill to capacity, then release
    repeat (6) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    check("full_in_ready", in_ready, 0);
    repeat (10) step(1'b0, W'($urandom), 1'b0, 1'b1);

    // Bubbles, then a 2-cycle stall that collapses them
    for (int i = 0; i < 8; i++)
      step(1'(i % 2 == 0), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b0, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'(i % 2 == 0), W'($urandom), 1'b1, 1'b1);
    repeat (6) step(1'b0, W'($urandom), 1'b0, 1'b1);

    // Randomized traffic
    repeat (400)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    repeat (12) step(1'b0, W'($urandom), 1'b0, 1'b1);

    // Asynchronous reset with three words held in the pipeline
    repeat (3) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    repeat (4) step(1'b0, W'($urandom), 1'b0, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_edge_count", edge_count, 0);
    check("async_rst_out_changed", out_changed, 0);
    check("async_rst_wrap_count", w_edge_count, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step(1'b0, W'($urandom), 1'b0, 1'b1);

    // Alternating words: 2-bit counter runs 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      step(1'b1, (i % 2 == 1) ? 8'hFF : 8'h00, 1'b0, 1'b1);
    repeat (7) step(1'b0, W'($urandom), 1'b0, 1'b1);
    check("wrap_final_count", w_edge_count, 0);
    check("alt_edge_count", edge_count, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_invert_pipe

// File: doc/invert_pipe.md
Name: invert_pipe

Overview:
- Clocked, parametrised successor to the event-driven inverter/sub-inverter pair.
- Passes WIDTH-bit words through DEPTH registered stages with a per-bit programmable inversion.
- Uses a valid/ready elastic handshake and reports output edges so mixed-signal testbenches can observe transitions.
- Sits between digital stimulus sources and the analog-interface boundary in gnucap co-simulation test designs.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages, which is also the zero-stall latency in cycles (>=1).
- INV_MASK, all ones (WIDTH bits), bits inverted when inversion is enabled.
- CNT_W, 16, width of the edge counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inv_en  in  1  inversion enable, sampled with each accepted input word.
- in_valid  in  1  input word present.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  last stage holds a word.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  last-stage word.
- out_changed  out  1  one-cycle pulse: accepted output differs from the previous accepted output.
- edge_count  out  CNT_W  count of out_changed pulses.

Behaviour:
- Reset (asynchronous, while rst=1):
  - all stage valid bits, stage data, last_out, out_changed and edge_count are 0.
  - in_ready=1 once reset is released.
- Stage 0 load value: in_data ^ (inv_en ? INV_MASK : 0). Inversion is applied once, at entry only.
- Per-stage advance rule:
  - stage k may load when it is empty, or when its content moves on in the same cycle.
  - the last stage moves on when out_valid && out_ready.
  - in_ready = !v0 || v0 advancing; ready is combinational through the chain.
- Transfers:
  - input transfer = in_valid && in_ready.
  - output transfer = out_valid && out_ready.
  - both may occur in the same cycle.
- Latency and throughput:
  - a word accepted at cycle t is at out_valid at t+DEPTH with no stall.
  - full throughput is 1 word per cycle.
- Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- Capacity: DEPTH words.
  - when full and out_ready=0, in_ready=0 and no data moves.
  - a word is never dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data holds stable.
- out_data when out_valid=0 is undefined for checking purposes; the RTL holds the last value.
- Edge detection on output transfer:
  - out_changed is registered and high the cycle after the transfer if out_data != last_out.
  - last_out is then updated to out_data.
  - the first transfer after reset compares against 0.
- edge_count:
  - increments with each out_changed pulse.
  - wraps modulo 2^CNT_W with no saturation.
- inv_en change mid-stream: affects only words accepted from that cycle onward; in-flight words are unchanged.
- Reset asserted mid-operation: in-flight words are discarded immediately and all outputs return to reset values.

Decomposition:
- Shared package invert_pkg holds:
  - default WIDTH/DEPTH constants.
  - a stage record typedef (valid bit + WIDTH data).
- Natural sub-module: invert_stage, one elastic register slice with ports valid/ready/data in and out.
  - invert_pipe generates DEPTH instances.
  - inversion and the edge detector live in the top level.

Test Plan (WIDTH=8, DEPTH=4 unless stated):
- Reset then stream 0x00,0x0F,0x0F,0xA5 with inv_en=1 and out_ready=1:
  - out_data 0xFF,0xF0,0xF0,0x5A at cycles 4..7.
  - out_changed pulses for 0xFF, 0xF0 and 0x5A only; edge_count=3.
- inv_en=0 stream 0x3C:
  - 0x3C out after 4 cycles.
  - toggle inv_en while the word is in flight: output is unaffected.
- Hold out_ready=0 and push 6 words:
  - in_ready drops after 4 words are accepted.
  - release out_ready: the words appear in order, none lost.
- Alternate in_valid 1/0 with out_ready=1:
  - bubbles propagate and output valid alternates.
  - stall out_ready for 2 cycles: bubbles collapse and in_ready stays 1 while any stage is empty.
- Assert rst asynchronously mid-stream (between clock edges) with 3 words in flight:
  - out_valid=0, edge_count=0 and out_changed=0 immediately.
  - no stale words appear after release.
- CNT_W=2, 5 alternating words 0x00/0xFF with inv_en=0: edge_count sequence 0,1,2,3,0 (wrap).
